ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
//  Per-frame controller for the pitch-driven ball sprite. Turns sampled voice frequency into a slew-limited
//  ball vertical centre, runs the game state machine, detects ball/pipe collisions and counts cleared pipes.
//  Sits between the pitch detector and the ball/pipe sprite renderers; outputs change only on frame pulses.
// PARAMETERS
//  Y_HEIGHT   208  base of ball travel; rest centre = Y_HEIGHT+20
//  Y_MAX      704  upper clamp on ball centre (px)
//  MAX_STEP   4    max |change| of ball_y_out per frame (px)
//  BALL_X     640  ball left edge; right edge = BALL_X+2*SPHERE_R
//  SPHERE_R   16   ball radius (px)
//  PIPE_W     32   pipe width (px)
//  GAP_H      96   pipe gap height (px)
//  HIT_FRAMES 60   frames the ball stays frozen after a hit
// PORTS
//  clk_in         in   1   pixel clock
//  rst_n_in       in   1   synchronous reset, active low
//  new_frame_in   in   1   1-cycle pulse at start of vertical blank
//  freq_in        in   16  detected frequency
//  freq_valid_in  in   1   freq_in valid this cycle
//  start_in       in   1   start request (level)
//  pipe_x_in      in   11  current pipe left edge
//  gap_y_in       in   10  current pipe gap top
//  ball_y_out     out  10  ball vertical centre
//  state_out      out  2   0=IDLE 1=PLAY 2=HIT
//  hit_out        out  1   1-cycle pulse on collision
//  score_out      out  8   pipes cleared, saturates at 255
// BEHAVIOUR
//  Reset (rst_n_in=0 at edge): ball_y_out=Y_HEIGHT+20, state IDLE, hit_out=0, score_out=0, freq_hold=0,
//   hit counter=0. A reset mid-frame or mid-HIT overrides everything; a new_frame_in on the same edge is lost.
//  freq_hold <= freq_in on every cycle with freq_valid_in=1, in all states. Otherwise it holds.
//  target = Y_HEIGHT+20+min(freq_hold>>2, 511), then clamped to Y_MAX. Compute in 11 bits so nothing wraps.
//  Frame update happens only on an edge with new_frame_in=1. Every output updates on that edge (latency 1 cycle).
//   Between pulses all outputs hold, except hit_out, which is 0.
//  IDLE: ball_y_out <= Y_HEIGHT+20. If start_in=1 -> PLAY and score_out <= 0.
//  PLAY:
//   - d = target-ball_y_out. ball_y_nxt = target if |d|<=MAX_STEP, else ball_y_out +/- MAX_STEP.
//     ball_y_out <= ball_y_nxt.
//   - Collision uses ball_y_nxt, pipe_x_in and gap_y_in.
//     x-overlap: pipe_x_in < BALL_X+2*SPHERE_R and pipe_x_in+PIPE_W > BALL_X.
//     Outside gap: ball_y_nxt-SPHERE_R < gap_y_in, or ball_y_nxt+SPHERE_R > gap_y_in+GAP_H.
//     x-overlap && outside gap -> hit_out <= 1, state -> HIT, hit counter <= HIT_FRAMES.
//   - Clear: pipe_x_in+PIPE_W <= BALL_X while cleared flag=0 -> score_out+1 (saturating), cleared flag <= 1.
//     The cleared flag resets when pipe_x_in+PIPE_W > BALL_X, i.e. a new pipe has entered.
//   - Collision and clear on the same frame: the collision wins and the score does not change.
//  HIT: ball_y_out frozen. Hit counter decrements once per frame; on the frame it reads 1 -> IDLE.
//   start_in is ignored in HIT.
//  Only the IDLE, PLAY and HIT state encodings are legal. The unused encoding 3 -> IDLE on the next frame.
// CONFIGURATION
//  FREQ_FILTER_EN defined:
//   - On each freq_valid_in, freq_hold <= freq_hold + ((freq_in - freq_hold) >>> 2).
//     Use a 17-bit signed difference, a 1st-order IIR with alpha=1/4.
//   - freq_hold is then used as above.
//  FREQ_FILTER_EN undefined: freq_hold <= freq_in directly. Ports and timing are identical in both builds.
// TESTING
//  1 Reset: hold rst_n_in=0 for 3 clk, then release -> ball_y_out=228, state_out=0, score_out=0, hit_out=0.
//  2 Slew (unfiltered build), PLAY, pipe_x_in=1200, freq 400 (target 328) -> ball_y_out 232, 236, ..., 328.
//    Reaches 328 on frame 25, then holds at 328.
//  3 Saturate/clamp: freq_in=16'hFFFF -> target clamps to 704, and ball_y_out never exceeds 704.
//    Then freq 0 -> ball descends 4 px/frame toward 228.
//  4 Collision: ball_y=328, pipe_x_in=650, gap_y_in=100 -> next frame hit_out=1 for exactly 1 clk, state_out=2.
//    After 60 frames state_out=0.
//  5 Clear: ball_y=328, gap_y_in=280, pipe_x_in steps 650 -> 600 -> 400 -> 1200 -> 600.
//    Expect no hit. score_out=1 when the pipe passes 600 (edge at 632 <= 640); it does not increment again
//    at 400. It becomes 2 at the second 600.
//  6 FREQ_FILTER_EN build: from freq_hold=0, apply freq 400 valid every cycle for 4 cycles -> freq_hold 100, 175, 231, 273.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//  Per-frame ball controller: turns the held voice frequency into a slew-limited
//  ball centre, runs the IDLE/PLAY/HIT game FSM, detects ball/pipe collisions
//  and counts cleared pipes. All game outputs change only on new_frame_in edges.
//  Build option: define FREQ_FILTER_EN to pass freq_in through a 1st-order IIR
//  (alpha = 1/4) before it is held; ports and timing are identical either way.
module ball_motion_ctrl #(
    parameter int unsigned Y_HEIGHT   = 208,
    parameter int unsigned Y_MAX      = 704,
    parameter int unsigned MAX_STEP   = 4,
    parameter int unsigned BALL_X     = 640,
    parameter int unsigned SPHERE_R   = 16,
    parameter int unsigned PIPE_W     = 32,
    parameter int unsigned GAP_H      = 96,
    parameter int unsigned HIT_FRAMES = 60
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        new_frame_in,
    input  logic [15:0] freq_in,
    input  logic        freq_valid_in,
    input  logic        start_in,
    input  logic [10:0] pipe_x_in,
    input  logic [9:0]  gap_y_in,
    output logic [9:0]  ball_y_out,
    output logic [1:0]  state_out,
    output logic        hit_out,
    output logic [7:0]  score_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    localparam int unsigned CNT_W = $clog2(HIT_FRAMES + 1);

    // Geometry constants widened to 12 bits so all sums below fit without wrap.
    localparam logic [11:0] REST_Y    = 12'(Y_HEIGHT + 20);
    localparam logic [11:0] Y_LIM     = 12'(Y_MAX);
    localparam logic [11:0] STEP      = 12'(MAX_STEP);
    localparam logic [11:0] BALL_L    = 12'(BALL_X);
    localparam logic [11:0] BALL_R    = 12'(BALL_X + 2 * SPHERE_R);
    localparam logic [11:0] RAD       = 12'(SPHERE_R);
    localparam logic [11:0] PIPE_WID  = 12'(PIPE_W);
    localparam logic [11:0] GAP_HGT   = 12'(GAP_H);
    localparam logic [15:0] FREQ_CAP  = 16'd511;
    localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HIT_FRAMES);
    localparam logic [9:0]  REST_Y10  = 10'(Y_HEIGHT + 20);

    state_t           state;
    logic [15:0]      freq_hold;
    logic [CNT_W-1:0] hit_cnt;
    logic             cleared;

    logic [15:0] freq_q;
    logic [11:0] freq_off;
    logic [11:0] target_raw;
    logic [11:0] target;
    logic [11:0] ball_cur;
    logic [11:0] ball_y_nxt;
    logic [11:0] pipe_l;
    logic [11:0] pipe_r;
    logic [11:0] gap_top;
    logic [11:0] gap_bot;
    logic        x_overlap;
    logic        outside_gap;
    logic        collide;
    logic        pipe_passed;

`ifdef FREQ_FILTER_EN
    logic signed [16:0] freq_diff;
    logic signed [16:0] freq_filt;

    // IIR step: hold + (freq - hold)/4 with an arithmetic shift on the signed difference.
    always_comb begin
        freq_diff = $signed({1'b0, freq_in}) - $signed({1'b0, freq_hold});
        freq_filt = $signed({1'b0, freq_hold}) + (freq_diff >>> 2);
    end

    // Filtered frequency hold, updated on every valid sample in every state.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            freq_hold <= '0;
        end else if (freq_valid_in) begin
            freq_hold <= freq_filt[15:0];
        end
    end
`else
    // Raw frequency hold, updated on every valid sample in every state.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            freq_hold <= '0;
        end else if (freq_valid_in) begin
            freq_hold <= freq_in;
        end
    end
`endif

    // Target centre from the held frequency, capped then clamped to the top limit.
    always_comb begin
        freq_q     = freq_hold >> 2;
        freq_off   = (freq_q > FREQ_CAP) ? 12'(FREQ_CAP) : {3'b000, freq_q[8:0]};
        target_raw = REST_Y + freq_off;
        target     = (target_raw > Y_LIM) ? Y_LIM : target_raw;
    end

    // Slew limiter: step toward target by at most STEP pixels per frame.
    always_comb begin
        ball_cur = {2'b00, ball_y_out};
        if (target >= ball_cur) begin
            ball_y_nxt = ((target - ball_cur) <= STEP) ? target : ball_cur + STEP;
        end else begin
            ball_y_nxt = ((ball_cur - target) <= STEP) ? target : ball_cur - STEP;
        end
    end

    // Collision and clear detection against the next ball position.
    // "centre - R < gap_top" is evaluated as "centre < gap_top + R" to avoid underflow.
    always_comb begin
        pipe_l      = {1'b0, pipe_x_in};
        pipe_r      = pipe_l + PIPE_WID;
        gap_top     = {2'b00, gap_y_in};
        gap_bot     = gap_top + GAP_HGT;
        x_overlap   = (pipe_l < BALL_R) && (pipe_r > BALL_L);
        outside_gap = (ball_y_nxt < gap_top + RAD) || (ball_y_nxt + RAD > gap_bot);
        collide     = x_overlap && outside_gap;
        pipe_passed = (pipe_r <= BALL_L);
    end

    // Game FSM with registered outputs; everything advances only on frame pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            ball_y_out <= REST_Y10;
            hit_out    <= 1'b0;
            score_out  <= '0;
            hit_cnt    <= '0;
            cleared    <= 1'b0;
        end else begin
            hit_out <= 1'b0;
            if (new_frame_in) begin
                case (state)
                    ST_IDLE: begin
                        ball_y_out <= REST_Y10;
                        if (start_in) begin
                            state     <= ST_PLAY;
                            score_out <= '0;
                        end
                    end
                    ST_PLAY: begin
                        ball_y_out <= ball_y_nxt[9:0];
                        // A collision implies x-overlap, which excludes a clear on the same frame.
                        if (collide) begin
                            hit_out <= 1'b1;
                            state   <= ST_HIT;
                            hit_cnt <= HIT_LOAD;
                        end
                        if (!pipe_passed) begin
                            cleared <= 1'b0;
                        end else if (!cleared) begin
                            cleared <= 1'b1;
                            if (score_out != 8'hFF) begin
                                score_out <= score_out + 8'd1;
                            end
                        end
                    end
                    ST_HIT: begin
                        if (hit_cnt <= CNT_W'(1)) begin
                            state <= ST_IDLE;
                        end
                        if (hit_cnt != '0) begin
                            hit_cnt <= hit_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl
//  Directed scenarios followed by randomized stimulus, every cycle compared
//  against an arithmetic reference model of the game rules.
module tb_ball_motion_ctrl;

    logic        clk;
    logic        rst_n;
    logic        new_frame;
    logic [15:0] freq;
    logic        freq_valid;
    logic        start;
    logic [10:0] pipe_x;
    logic [9:0]  gap_y;
    logic [9:0]  ball_y;
    logic [1:0]  state;
    logic        hit;
    logic [7:0]  score;

    int n_checks;
    int n_errors;

    // Reference model state
    int m_ball;
    int m_state;
    int m_hit;
    int m_score;
    int m_hold;
    int m_cnt;
    int m_cleared;

    ball_motion_ctrl #(
        .Y_HEIGHT  (208),
        .Y_MAX     (704),
        .MAX_STEP  (4),
        .BALL_X    (640),
        .SPHERE_R  (16),
        .PIPE_W    (32),
        .GAP_H     (96),
        .HIT_FRAMES(60)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .new_frame_in (new_frame),
        .freq_in      (freq),
        .freq_valid_in(freq_valid),
        .start_in     (start),
        .pipe_x_in    (pipe_x),
        .gap_y_in     (gap_y),
        .ball_y_out   (ball_y),
        .state_out    (state),
        .hit_out      (hit),
        .score_out    (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Game rules applied to the inputs present at a clock edge.
    task automatic model_edge();
        int tgt, d, nxt, pr;
        bit xo, outside;
        if (!rst_n) begin
            m_ball = 228; m_state = 0; m_hit = 0; m_score = 0;
            m_hold = 0; m_cnt = 0; m_cleared = 0;
            return;
        end
        m_hit = 0;
        if (new_frame) begin
            if (m_state == 0) begin
                m_ball = 228;
                if (start) begin
                    m_state = 1;
                    m_score = 0;
                end
            end else if (m_state == 1) begin
                tgt = 228 + ((m_hold / 4 > 511) ? 511 : m_hold / 4);
                if (tgt > 704) tgt = 704;
                d = tgt - m_ball;
                if (d >= -4 && d <= 4) nxt = tgt;
                else nxt = (d > 0) ? m_ball + 4 : m_ball - 4;
                pr = int'(pipe_x) + 32;
                xo = (int'(pipe_x) < 672) && (pr > 640);
                outside = (nxt - 16 < int'(gap_y)) || (nxt + 16 > int'(gap_y) + 96);
                if (xo && outside) begin
                    m_hit = 1;
                    m_state = 2;
                    m_cnt = 60;
                end else if (pr <= 640 && m_cleared == 0) begin
                    m_cleared = 1;
                    if (m_score < 255) m_score++;
                end
                if (pr > 640) m_cleared = 0;
                m_ball = nxt;
            end else begin
                if (m_cnt == 1) m_state = 0;
                m_cnt--;
            end
        end
        if (freq_valid) begin
`ifdef FREQ_FILTER_EN
            m_hold = m_hold + ((int'(freq) - m_hold) >>> 2);
`else
            m_hold = int'(freq);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ball_y", int'(ball_y), m_ball);
        check_eq("state", int'(state), m_state);
        check_eq("hit", int'(hit), m_hit);
        check_eq("score", int'(score), m_score);
    endtask

    task automatic frame();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic drive_freq(input int f, input int n);
        freq = 16'(f);
        freq_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        freq_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; new_frame = 1'b0; freq = '0; freq_valid = 1'b0;
        start = 1'b0; pipe_x = 11'd1200; gap_y = 10'd300;

        // Reset
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        check_eq("rst_ball", int'(ball_y), 228);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_hit", int'(hit), 0);
        step();

        // Slew toward target 328
        drive_freq(400, 60);
        start = 1'b1;
        frame();
        start = 1'b0;
        check_eq("t2_play", int'(state), 1);
        frame();
`ifndef FREQ_FILTER_EN
        check_eq("t2_first", int'(ball_y), 232);
`endif
        frames(24);
`ifndef FREQ_FILTER_EN
        check_eq("t2_reach", int'(ball_y), 328);
`endif
        frames(3);
`ifndef FREQ_FILTER_EN
        check_eq("t2_hold", int'(ball_y), 328);
`endif

        // Collision and HIT hold-off
        pipe_x = 11'd650; gap_y = 10'd100;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        check_eq("t4_hit", int'(hit), 1);
        check_eq("t4_state", int'(state), 2);
        step();
        check_eq("t4_hit_low", int'(hit), 0);
        pipe_x = 11'd1200;
        start = 1'b1;
        frames(59);
        check_eq("t4_still_hit", int'(state), 2);
        frame();
        start = 1'b0;
        check_eq("t4_idle", int'(state), 0);

        // Clearing pipes
        gap_y = 10'd280;
        start = 1'b1;
        frame();
        start = 1'b0;
        frames(25);
        pipe_x = 11'd650;  frame();
        check_eq("t5_nohit", int'(state), 1);
        pipe_x = 11'd600;  frame();
        check_eq("t5_s1", int'(score), 1);
        pipe_x = 11'd400;  frame();
        check_eq("t5_s1b", int'(score), 1);
        pipe_x = 11'd1200; frame();
        check_eq("t5_s1c", int'(score), 1);
        pipe_x = 11'd600;  frame();
        check_eq("t5_s2", int'(score), 2);

        // Clamp and descent
        pipe_x = 11'd1200;
        drive_freq(16'hFFFF, 60);
        frames(100);
        check_eq("t3_clamp", int'(ball_y), 704);
        drive_freq(0, 60);
        frames(10);
        check_eq("t3_desc", int'(ball_y), 664);

        // Randomized play
        pipe_x = 11'd1100;
        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 599) != 0);
            new_frame  = ($urandom_range(0, 3) == 0);
            freq_valid = ($urandom_range(0, 2) == 0);
            freq       = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1600));
            start      = ($urandom_range(0, 3) != 0);
            if (new_frame) begin
                if (pipe_x < 11'd60) begin
                    pipe_x = 11'($urandom_range(900, 1400));
                    gap_y  = 10'($urandom_range(150, 600));
                end else begin
                    pipe_x = pipe_x - 11'($urandom_range(4, 40));
                end
            end
            step();
        end
        rst_n = 1'b1;
        new_frame = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
